if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req_valid  output  1  instruction-memory read request valid.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_rsp_valid  input  1  read data valid; exactly one per accepted request, at least 1 cycle after acceptance, in order.
REQ-008 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-009 SHALL have port redirect_valid  input  1  control-flow change from execute (branch/JAL/JALR).
REQ-010 SHALL have port redirect_pc  input  32  new fetch target.
REQ-011 SHALL have port instr_valid  output  1  instruction available to the decoder.
REQ-012 SHALL have port instr_ready  input  1  decoder consumes instruction.
REQ-013 SHALL have port instr  output  32  instruction word, feeds the decoder instruction input.
REQ-014 SHALL have port instr_pc  output  32  address of instr.
REQ-015 SHALL have port instr_illegal  output  1  instr[1:0] != 2'b11 (see Configuration).

Function
REQ-016 SHALL hold fetch PC register pc; imem_req_addr = pc when imem_req_valid is high.
REQ-017 SHALL keep at most one request outstanding (accepted, response not yet received).
REQ-018 SHALL assert imem_req_valid only when no request is outstanding and output buffer occupancy is < 2, so every response has a reserved slot.
REQ-019 SHALL, once imem_req_valid is high, hold it and imem_req_addr stable until imem_req_ready, except in a redirect cycle (REQ-025).
REQ-020 SHALL, on handshake (imem_req_valid & imem_req_ready), set pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 SHALL implement a 3-state FSM: IDLE (cannot issue: buffer reserved full), REQ (imem_req_valid high), WAIT (outstanding); REQ->WAIT on handshake; WAIT->REQ or IDLE on imem_rsp_valid per REQ-018; IDLE->REQ when occupancy drops.
REQ-022 SHALL write each non-killed response {data, address} into a 2-entry in-order FIFO; data appears on instr_valid/instr the cycle after imem_rsp_valid (1-cycle latency when FIFO empty).
REQ-023 SHALL pop FIFO head when instr_valid & instr_ready; simultaneous push and pop leaves occupancy unchanged; instr/instr_pc SHALL hold stable while instr_valid & !instr_ready.
REQ-024 SHALL drive instr_valid = (occupancy != 0); instr/instr_pc = FIFO head.
REQ-025 SHALL, on redirect_valid: set pc <= {redirect_pc[31:2], 2'b00}; flush FIFO (instr_valid low next cycle); set kill flag if a request is outstanding or is handshaking in the same cycle.
REQ-026 SHALL discard the response matching a killed request (no FIFO write), clear kill on that response, and issue a request for the new pc no earlier than the following cycle.
REQ-027 SHALL, when redirect coincides with imem_rsp_valid of a live request, discard that response.
REQ-028 SHALL give redirect priority over pc+4 update and over FIFO push/pop in the same cycle.

Reset
REQ-029 SHALL on rst_n low asynchronously set pc=RESET_PC, FSM=REQ-pending with occupancy 0, kill=0, no outstanding request.
REQ-030 SHALL drive during reset imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, instr_illegal=0, imem_req_addr=0.
REQ-031 SHALL assert imem_req_valid with imem_req_addr=RESET_PC in the first cycle after rst_n deasserts.
REQ-032 SHALL, on reset mid-operation, abandon any outstanding request; its late response is ignored.

Configuration
REQ-033 SHALL, with IF_FETCH_ILLEGAL_CHECK_EN defined, store per FIFO entry a flag = (imem_rsp_data[1:0] != 2'b11) and drive instr_illegal from the head entry.
REQ-034 SHALL, without IF_FETCH_ILLEGAL_CHECK_EN, tie instr_illegal to 0 and omit the flag storage.

Verification
REQ-035 SHALL cover reset release, ready=1, response next cycle 32'h0000_0013 -> req addr 0,4,8,...; instr_valid cycle after each response, instr_pc 0,4,8.
REQ-036 SHALL cover instr_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req_valid low, instr/instr_pc stable; ready=1 -> drains in order, fetch resumes.
REQ-037 SHALL cover redirect to 32'h0000_0102 while a request is outstanding -> its response dropped, next req addr 32'h0000_0100, FIFO flushed.
REQ-038 SHALL cover redirect to 32'hFFFF_FFFC -> req addrs FFFF_FFFC then 0000_0000.
REQ-039 SHALL cover response data 32'h0000_0000 with IF_FETCH_ILLEGAL_CHECK_EN -> instr_illegal=1; without macro -> 0.
REQ-040 SHALL cover imem_req_ready held low 5 cycles -> imem_req_valid and imem_req_addr stable throughout.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: a single-outstanding imem requester feeding a 2-entry in-order instruction FIFO.
// Define IF_FETCH_ILLEGAL_CHECK_EN to store and output a per-entry illegal-encoding flag.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc, out_pc;
  logic             kill, kill_nxt;
  logic [1:0]       cnt, cnt_nxt;
  logic             rd_ptr, wr_ptr;
  logic [1:0][31:0] fifo_data, fifo_pc;
  logic             hs, rsp_live, push, pop;

  // Reset state is REQ, so gate with rst_n to keep the request quiet while reset is held.
  assign imem_req_valid = rst_n & (state == S_REQ);
  assign imem_req_addr  = imem_req_valid ? pc : 32'h0;
  assign hs             = imem_req_valid & imem_req_ready;
  assign rsp_live       = imem_rsp_valid & (state == S_WAIT);
  assign push           = rsp_live & ~kill & ~redirect_valid;
  assign pop            = instr_valid & instr_ready & ~redirect_valid;

  assign instr_valid = (cnt != 2'd0);
  assign instr       = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    if (redirect_valid)
      cnt_nxt = 2'd0;
    else if (push && !pop)
      cnt_nxt = cnt + 2'd1;
    else if (pop && !push)
      cnt_nxt = cnt - 2'd1;
  end

  // Issue only while a FIFO slot is guaranteed for the response.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (hs) state_nxt = S_WAIT;
      S_WAIT:  if (rsp_live) state_nxt = (cnt_nxt < 2'd2) ? S_REQ : S_IDLE;
      S_IDLE:  if (cnt_nxt < 2'd2) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    kill_nxt = kill;
    if (rsp_live)
      kill_nxt = 1'b0;
    if (redirect_valid && (hs || (state == S_WAIT && !imem_rsp_valid)))
      kill_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      out_pc <= 32'h0;
      kill   <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      cnt   <= cnt_nxt;
      if (hs)
        out_pc <= pc;
      if (redirect_valid)
        pc <= {redirect_pc[31:2], 2'b00};
      else if (hs)
        pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data <= '0;
      fifo_pc   <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
    end else if (redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= imem_rsp_data;
        fifo_pc[wr_ptr]   <= out_pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
    end
  end

`ifdef IF_FETCH_ILLEGAL_CHECK_EN
  logic [1:0] fifo_ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fifo_ill <= '0;
    else if (push && !redirect_valid)
      fifo_ill[wr_ptr] <= (imem_rsp_data[1:0] != 2'b11);
  end

  assign instr_illegal = fifo_ill[rd_ptr];
`else
  assign instr_illegal = 1'b0;
`endif

endmodule
